// File: rtl/countn_pkg.sv
// Shared constants and helpers for the countn counter: load clamping and
// elaboration-time parameter checks.
package countn_pkg;

    localparam int unsigned COUNTN_MAX_WIDTH = 32;

    function automatic logic [31:0] countn_clamp(input logic [31:0] value,
                                                 input logic [31:0] max_val);
        return (value > max_val) ? max_val : value;
    endfunction

    function automatic bit countn_width_ok(input int unsigned width);
        return (width >= 2) && (width <= COUNTN_MAX_WIDTH);
    endfunction

    function automatic bit countn_max_ok(input logic [31:0] max_val);
        return max_val != 32'd0;
    endfunction

    function automatic bit countn_reset_ok(input logic [31:0] reset_val,
                                           input logic [31:0] max_val);
        return reset_val <= max_val;
    endfunction

endpackage

// File: rtl/countn_step.sv
// Combinational next-value unit for countn. Wraps at the bound by default;
// holds at the bound when COUNTN_SAT_EN is defined.
module countn_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             up,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] nxt,
    output logic             bound
);

    always_comb begin
        bound = up ? (cnt == max_val) : (cnt == '0);
`ifdef COUNTN_SAT_EN
        if (bound) begin
            nxt = cnt;
        end else begin
            nxt = up ? (cnt + WIDTH'(1)) : (cnt - WIDTH'(1));
        end
`else
        if (bound) begin
            nxt = up ? '0 : max_val;
        end else begin
            nxt = up ? (cnt + WIDTH'(1)) : (cnt - WIDTH'(1));
        end
`endif
    end

endmodule

// File: rtl/countn.sv
// Parametrised loadable up/down modulo-N counter with registered terminal-count
// pulse. Define COUNTN_SAT_EN for saturating instead of wrapping behaviour.
module countn
    import countn_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    if (!countn_width_ok(WIDTH)) begin : g_bad_width
        $fatal(1, "countn: WIDTH must be in 2..32");
    end
    if (!countn_max_ok(32'(MAX_VAL))) begin : g_bad_max
        $fatal(1, "countn: MAX_VAL must be at least 1");
    end
    if (!countn_reset_ok(32'(RESET_VAL), 32'(MAX_VAL))) begin : g_bad_reset
        $fatal(1, "countn: RESET_VAL must not exceed MAX_VAL");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] step_nxt;
    logic             step_bound;

    countn_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .cnt    (cnt_q),
        .up     (up),
        .max_val(MAX_VAL),
        .nxt    (step_nxt),
        .bound  (step_bound)
    );

    // Reset is handled in the flop process; here load beats enable beats hold.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (load) begin
            cnt_d = WIDTH'(countn_clamp(32'(cnt_in), 32'(MAX_VAL)));
        end else if (en) begin
            cnt_d = step_nxt;
            tc_d  = step_bound;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q <= RESET_VAL;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = tc_q;

endmodule

// File: tb/tb_countn.sv
// Self-checking bench for countn: one modulo-10 instance (RESET_VAL=3) and one
// default-parameter instance, checked against an arithmetic reference model.
module tb_countn;

    logic       clk = 1'b0;
    logic       res, en, load, up;
    logic [7:0] cnt_in;
    logic [7:0] cnt_a, cnt_b;
    logic       tc_a, tc_b;

    int n_cmp = 0;
    int n_err = 0;

    int a_cnt = 3;
    int b_cnt = 0;
    bit a_tc  = 1'b0;
    bit b_tc  = 1'b0;

    always #5 clk = ~clk;

    countn #(
        .WIDTH    (8),
        .MAX_VAL  (8'd9),
        .RESET_VAL(8'd3)
    ) dut_a (
        .clk   (clk),
        .res   (res),
        .en    (en),
        .load  (load),
        .up    (up),
        .cnt_in(cnt_in),
        .cnt   (cnt_a),
        .tc    (tc_a)
    );

    countn #(
        .WIDTH(8)
    ) dut_b (
        .clk   (clk),
        .res   (res),
        .en    (en),
        .load  (load),
        .up    (up),
        .cnt_in(cnt_in),
        .cnt   (cnt_b),
        .tc    (tc_b)
    );

    // Reference rules: counting is modular over MAX_VAL+1 values.
    task automatic model_next(input int cur, input int maxv, input int rstv,
                              output int n, output bit t);
        t = 1'b0;
        if (res) begin
            n = rstv;
        end else if (load) begin
            n = (int'(cnt_in) > maxv) ? maxv : int'(cnt_in);
        end else if (en) begin
            if (up) begin
                t = (cur == maxv);
`ifdef COUNTN_SAT_EN
                n = t ? maxv : cur + 1;
`else
                n = (cur + 1) % (maxv + 1);
`endif
            end else begin
                t = (cur == 0);
`ifdef COUNTN_SAT_EN
                n = t ? 0 : cur - 1;
`else
                n = (cur + maxv) % (maxv + 1);
`endif
            end
        end else begin
            n = cur;
        end
    endtask

    task automatic tick(input string tag);
        int na, nb;
        bit ta, tb;
        @(posedge clk);
        model_next(a_cnt, 9, 3, na, ta);
        model_next(b_cnt, 255, 0, nb, tb);
        a_cnt = na; a_tc = ta;
        b_cnt = nb; b_tc = tb;
        #1;
        $display("[%0t] %s res=%0d load=%0d en=%0d up=%0d in=%0d | a=%0d tc=%0d | b=%0d tc=%0d",
                 $time, tag, res, load, en, up, cnt_in, cnt_a, tc_a, cnt_b, tc_b);
    endtask

    task automatic test_reset();
        res = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; cnt_in = 8'd77;
        tick("reset");
        n_cmp++;
        if (cnt_a !== 8'd3 || tc_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_a: got cnt=%0d tc=%0d, want cnt=3 tc=0", cnt_a, tc_a);
        end
        n_cmp++;
        if (cnt_b !== 8'd0 || tc_b !== 1'b0) begin
            n_err++;
            $display("FAIL reset_b: got cnt=%0d tc=%0d, want cnt=0 tc=0", cnt_b, tc_b);
        end
        res = 1'b0;
    endtask

    task automatic test_count_up();
        load = 1'b1; en = 1'b0; cnt_in = 8'd0;
        tick("up_load0");
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick("up");
            n_cmp++;
            if (cnt_a !== 8'(a_cnt) || tc_a !== a_tc) begin
                n_err++;
                $display("FAIL count_up[%0d]: got cnt=%0d tc=%0d, want cnt=%0d tc=%0d",
                         i, cnt_a, tc_a, a_cnt, a_tc);
            end
`ifndef COUNTN_SAT_EN
            n_cmp++;
            if (cnt_a !== 8'((i + 1) % 10) || tc_a !== ((i + 1) % 10 == 0)) begin
                n_err++;
                $display("FAIL count_up_seq[%0d]: got cnt=%0d tc=%0d, want cnt=%0d",
                         i, cnt_a, tc_a, (i + 1) % 10);
            end
`endif
        end
    endtask

    task automatic test_load_clamp_down();
        load = 1'b1; en = 1'b0; cnt_in = 8'd200;
        tick("clamp");
        n_cmp++;
        if (cnt_a !== 8'd9 || tc_a !== 1'b0) begin
            n_err++;
            $display("FAIL load_clamp: got cnt=%0d tc=%0d, want cnt=9 tc=0", cnt_a, tc_a);
        end
        n_cmp++;
        if (cnt_b !== 8'd200) begin
            n_err++;
            $display("FAIL load_noclamp_b: got cnt=%0d, want 200", cnt_b);
        end
        load = 1'b0; en = 1'b1; up = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tick("down");
            n_cmp++;
            if (cnt_a !== 8'(a_cnt) || tc_a !== a_tc) begin
                n_err++;
                $display("FAIL count_down[%0d]: got cnt=%0d tc=%0d, want cnt=%0d tc=%0d",
                         i, cnt_a, tc_a, a_cnt, a_tc);
            end
`ifndef COUNTN_SAT_EN
            n_cmp++;
            if (cnt_a !== 8'((18 - i) % 10) || tc_a !== ((18 - i) % 10 == 9)) begin
                n_err++;
                $display("FAIL count_down_seq[%0d]: got cnt=%0d tc=%0d, want cnt=%0d",
                         i, cnt_a, tc_a, (18 - i) % 10);
            end
`endif
        end
    endtask

    task automatic test_priority();
        res = 1'b1; load = 1'b1; en = 1'b1; cnt_in = 8'd5;
        tick("prio_res");
        n_cmp++;
        if (cnt_a !== 8'd3 || tc_a !== 1'b0) begin
            n_err++;
            $display("FAIL prio_reset: got cnt=%0d tc=%0d, want cnt=3 tc=0", cnt_a, tc_a);
        end
        res = 1'b0; load = 1'b1; en = 1'b0; cnt_in = 8'd5;
        tick("prio_load");
        n_cmp++;
        if (cnt_a !== 8'd5 || cnt_b !== 8'd5) begin
            n_err++;
            $display("FAIL prio_load: got a=%0d b=%0d, want 5 and 5", cnt_a, cnt_b);
        end
        load = 1'b0;
    endtask

    task automatic test_default_wrap();
        load = 1'b1; en = 1'b0; cnt_in = 8'd255;
        tick("def_load");
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick("def_step");
        n_cmp++;
        if (cnt_b !== 8'(b_cnt) || tc_b !== b_tc) begin
            n_err++;
            $display("FAIL default_top: got cnt=%0d tc=%0d, want cnt=%0d tc=%0d",
                     cnt_b, tc_b, b_cnt, b_tc);
        end
`ifndef COUNTN_SAT_EN
        n_cmp++;
        if (cnt_b !== 8'd0 || tc_b !== 1'b1) begin
            n_err++;
            $display("FAIL default_wrap: got cnt=%0d tc=%0d, want cnt=0 tc=1", cnt_b, tc_b);
        end
`endif
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick("def_hold");
            n_cmp++;
            if (cnt_b !== 8'(b_cnt) || tc_b !== 1'b0) begin
                n_err++;
                $display("FAIL default_hold[%0d]: got cnt=%0d tc=%0d, want cnt=%0d tc=0",
                         i, cnt_b, tc_b, b_cnt);
            end
        end
    endtask

    task automatic test_bounds();
        load = 1'b1; en = 1'b0; cnt_in = 8'd8;
        tick("bnd_load8");
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick("bnd_up");
            n_cmp++;
            if (cnt_a !== 8'(a_cnt) || tc_a !== a_tc) begin
                n_err++;
                $display("FAIL bound_up[%0d]: got cnt=%0d tc=%0d, want cnt=%0d tc=%0d",
                         i, cnt_a, tc_a, a_cnt, a_tc);
            end
        end
        load = 1'b1; en = 1'b0; cnt_in = 8'd0;
        tick("bnd_load0");
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick("bnd_down");
        n_cmp++;
        if (cnt_a !== 8'(a_cnt) || tc_a !== 1'b1) begin
            n_err++;
            $display("FAIL bound_down: got cnt=%0d tc=%0d, want cnt=%0d tc=1",
                     cnt_a, tc_a, a_cnt);
        end
    endtask

    task automatic test_back_to_back();
        load = 1'b1; en = 1'b0; cnt_in = 8'd0;
        tick("b2b_load");
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            up = (i % 2 == 1);
            tick("b2b");
            n_cmp++;
            if (cnt_a !== 8'(a_cnt) || tc_a !== a_tc) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got cnt=%0d tc=%0d, want cnt=%0d tc=%0d",
                         i, cnt_a, tc_a, a_cnt, a_tc);
            end
        end
    endtask

    task automatic test_reset_mid();
        load = 1'b1; en = 1'b0; cnt_in = 8'd6;
        tick("mid_load");
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick("mid_step");
        n_cmp++;
        if (cnt_a !== 8'd7) begin
            n_err++;
            $display("FAIL mid_pre: got cnt=%0d, want 7", cnt_a);
        end
        res = 1'b1;
        tick("mid_res");
        n_cmp++;
        if (cnt_a !== 8'd3 || tc_a !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: got cnt=%0d tc=%0d, want cnt=3 tc=0", cnt_a, tc_a);
        end
        res = 1'b0;
        tick("mid_resume");
        n_cmp++;
        if (cnt_a !== 8'd4 || tc_a !== 1'b0) begin
            n_err++;
            $display("FAIL mid_resume: got cnt=%0d tc=%0d, want cnt=4 tc=0", cnt_a, tc_a);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            res    = ($urandom_range(0, 24) == 0);
            load   = ($urandom_range(0, 7) == 0);
            en     = ($urandom_range(0, 3) != 0);
            up     = $urandom_range(0, 1) == 1;
            cnt_in = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12))
                                                 : 8'($urandom_range(0, 255));
            tick("rand");
            n_cmp++;
            if (cnt_a !== 8'(a_cnt) || tc_a !== a_tc) begin
                n_err++;
                $display("FAIL random_a[%0d]: got cnt=%0d tc=%0d, want cnt=%0d tc=%0d",
                         i, cnt_a, tc_a, a_cnt, a_tc);
            end
            n_cmp++;
            if (cnt_b !== 8'(b_cnt) || tc_b !== b_tc) begin
                n_err++;
                $display("FAIL random_b[%0d]: got cnt=%0d tc=%0d, want cnt=%0d tc=%0d",
                         i, cnt_b, tc_b, b_cnt, b_tc);
            end
        end
        res = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        res = 1'b1; en = 1'b0; load = 1'b0; up = 1'b1; cnt_in = 8'd0;
        test_reset();
        test_count_up();
        test_load_clamp_down();
        test_priority();
        test_default_wrap();
        test_bounds();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
